// File: rtl/dgiota_pkg.sv
// Shared types and constants for the dgiota SAR controller slice.
package dgiota_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } sar_state_t;

  localparam int SYNC_STAGES  = 2;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_SETTLE_W = 4;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/dgiota_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset.
module dgiota_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dgiota_sar_ctrl.sv
// Successive-approximation controller driving the analog macro's DAC code.
// Optional macro SAR_SETTLE_EN: adds settle_cycles extra settle cycles per bit.
module dgiota_sar_ctrl
  import dgiota_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SETTLE_W = DEF_SETTLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                comp_in,
  output logic [WIDTH-1:0]    dac_code,
  output logic                busy,
  output logic [WIDTH-1:0]    result,
  output logic                result_valid
);

  localparam int IDX_W = idx_width(WIDTH);
`ifdef SAR_SETTLE_EN
  localparam int CNT_W = SETTLE_W + 1;
`else
  localparam int CNT_W = 1;
`endif

  sar_state_t       r_state;
  logic [WIDTH-1:0] r_dac;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_busy;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic             w_comp_s;
  logic [CNT_W-1:0] w_load;
  logic [WIDTH-1:0] w_kept;
  logic [WIDTH-1:0] w_next;

  dgiota_sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (comp_in),
    .o_q (w_comp_s)
  );

  // Reload value is N-1; the SETTLE count covers the synchronizer latency.
`ifdef SAR_SETTLE_EN
  assign w_load = CNT_W'(SYNC_STAGES - 1) + CNT_W'(settle_cycles);
`else
  logic w_unused_settle;
  assign w_unused_settle = ^settle_cycles;
  assign w_load          = CNT_W'(SYNC_STAGES - 1);
`endif

  always_comb begin
    w_kept        = r_dac;
    w_kept[r_idx] = w_comp_s;
    w_next        = w_kept;
    if (r_idx != '0) w_next[IDX_W'(r_idx - 1'b1)] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_dac    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state <= SETTLE;
            r_dac   <= {1'b1, {(WIDTH-1){1'b0}}};
            r_idx   <= IDX_W'(WIDTH - 1);
            r_cnt   <= w_load;
            r_busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            r_state <= IDLE;
            r_dac   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            r_state <= IDLE;
            r_dac   <= '0;
            r_busy  <= 1'b0;
          end else if (r_idx != '0) begin
            r_state <= SETTLE;
            r_dac   <= w_next;
            r_idx   <= r_idx - 1'b1;
            r_cnt   <= w_load;
          end else begin
            r_state  <= IDLE;
            r_dac    <= w_kept;
            r_result <= w_kept;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dac   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_code     = r_dac;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_dgiota_sar_ctrl.sv
// Scoreboard bench for dgiota_sar_ctrl; comparator modelled as VIN >= dac_code.
module tb_dgiota_sar_ctrl;

`ifdef SAR_SETTLE_EN
  localparam int NN = 7;
`else
  localparam int NN = 2;
`endif
  localparam int W  = 8;
  localparam int TT = W * (NN + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] settle_cycles = 4'd5;
  logic       comp_in;
  logic [7:0] dac_code;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic [7:0] vin = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] last_result = 8'h00;

  always #5 clk = ~clk;
  assign comp_in = (vin >= dac_code);

  dgiota_sar_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .settle_cycles (settle_cycles),
    .comp_in       (comp_in),
    .dac_code      (dac_code),
    .busy          (busy),
    .result        (result),
    .result_valid  (result_valid)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dac_code, busy, result, result_valid} !== 18'd0) begin
      errors++;
      $display("FAIL reset: dac=%h busy=%b res=%h rv=%b required all 0", dac_code, busy, result, result_valid);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_convert(input logic [7:0] v);
    logic [7:0] code;
    logic [7:0] trial [W];
    code = 8'h00;
    for (int j = 0; j < W; j++) begin
      trial[j] = code | (8'h80 >> j);
      if (v >= trial[j]) code = trial[j];
    end
    sb.push_back(code);
    vin = v;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int e = 0; e <= TT; e++) begin
      checks++;
      if (e < TT) begin
        if (busy !== 1'b1 || result_valid !== 1'b0 || dac_code !== trial[e/(NN+1)]) begin
          errors++;
          $display("FAIL conv_%h e=%0d: busy=%b rv=%b dac=%h required 1 0 %h", v, e, busy, result_valid, dac_code, trial[e/(NN+1)]);
        end
      end else if (busy !== 1'b0 || result_valid !== 1'b1) begin
        errors++;
        $display("FAIL conv_%h done e=%0d: busy=%b rv=%b required 0 1", v, e, busy, result_valid);
      end
      if (result_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL conv_%h unexpected rv: result=%h required none", v, result);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          if (result !== exp) begin
            errors++;
            $display("FAIL conv_%h result: got %h required %h", v, result, exp);
          end
        end
      end
      if (e < TT) @(posedge clk) #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL conv_%h missing result: pending=%0d required 0", v, sb.size());
      sb.delete();
    end
    last_result = code;
  endtask

  task automatic test_abort();
    bit bad;
    vin = 8'h33;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (2 * (NN + 1) + 1) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk) #1;
    checks++;
    if (busy !== 1'b0 || dac_code !== 8'h00 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b dac=%h rv=%b required 0 00 0", busy, dac_code, result_valid);
    end
    abort = 1'b0;
    bad = 1'b0;
    repeat (TT + 4) begin
      @(posedge clk) #1;
      if (result_valid || busy) bad = 1'b1;
    end
    checks++;
    if (bad || result !== last_result) begin
      errors++;
      $display("FAIL abort_after: stray=%b result=%h required 0 %h", bad, result, last_result);
    end
  endtask

  task automatic test_rst_mid();
    vin = 8'h55;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dac_code, busy, result, result_valid} !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid: dac=%h busy=%b res=%h rv=%b required all 0", dac_code, busy, result, result_valid);
    end
    @(negedge clk) rst = 1'b0;
    last_result = 8'h00;
    test_convert(8'h81);
  endtask

  task automatic test_start_abort_idle();
    logic [7:0] held;
    held = dac_code;
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    repeat (4) begin
      @(posedge clk) #1;
      checks++;
      if (busy !== 1'b0 || dac_code !== held) begin
        errors++;
        $display("FAIL start_abort_idle: busy=%b dac=%h required 0 %h", busy, dac_code, held);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int seen;
    vin = 8'hC3;
    sb.push_back(8'hC3);
    sb.push_back(8'hC3);
    seen = 0;
    @(negedge clk) start = 1'b1;
    cyc = 0;
    while (seen < 2 && cyc < 4 * TT) begin
      @(posedge clk) #1;
      cyc++;
      if (result_valid) begin
        logic [7:0] exp;
        seen++;
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (result !== exp) begin
          errors++;
          $display("FAIL b2b result%0d: got %h required %h", seen, result, exp);
        end
        if (seen == 1) begin
          @(posedge clk) #1;
          cyc++;
          checks++;
          if (busy !== 1'b1 || dac_code !== 8'h80) begin
            errors++;
            $display("FAIL b2b restart: busy=%b dac=%h required 1 80", busy, dac_code);
          end
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL b2b timeout: results=%0d required 2", seen);
    end
    sb.delete();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_convert(8'h5A);
    test_convert(8'h00);
    test_convert(8'hFF);
    test_abort();
    test_rst_mid();
    test_start_abort_idle();
    test_convert(8'hA7);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
